// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key-event path.
//   - PS/2 byte constants (extended prefix, break prefix, shift and caps codes)
//   - list of status/response bytes that never represent a key
//   - prefix FSM state encoding
//   - event record {code, shift, ext} pushed into the event FIFO (10 bits)
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    // Keyboard status / ack / error bytes; not key codes.
    localparam int         PS2_NUM_STATUS = 5;
    localparam logic [7:0] PS2_STATUS [PS2_NUM_STATUS] =
        '{8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       shift;
        logic       ext;
    } ps2_evt_t;

    localparam int PS2_EVT_W = $bits(ps2_evt_t);

    function automatic logic is_status(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_STATUS; i++) begin
            if (b == PS2_STATUS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: first-word-fall-through FIFO for key events.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request and data
//   pop             consume the head entry (ignored when empty)
//   pop_data        head entry, valid whenever empty=0 (zero when empty)
//   full, empty     occupancy flags
//   overflow        registered one-cycle pulse after a dropped push
// A push while full is accepted when a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty; pointers wrap naturally.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Zeroed when empty so the presented fields read 0 out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !do_pop;
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_key_events.sv
// ps2_key_events: turns the raw PS/2 byte stream into key-press events.
// Strips E0/F0 prefixes, tracks left/right shift, discards breaks, status
// bytes and shift codes, and queues make events in ps2_evt_fifo.
// Optional feature macro: PS2_CAPS_LOCK_EN (caps-lock toggle on make 58).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   byte_in, byte_valid received byte and its one-cycle strobe
//   out_ready           consumer accepts the head event
//   out_valid           head event presented (FIFO non-empty)
//   char_out, shift, ext head event fields
//   caps                caps-lock state (0 when feature disabled)
//   overflow            one-cycle pulse after a dropped event
//   dbg_state           prefix FSM state, for observation only
// Output handshake: an event transfers on every rising edge where
// out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0 the head
// fields hold steady. out_valid never depends on out_ready.
module ps2_key_events
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] char_out,
    output logic       shift,
    output logic       ext,
    output logic       caps,
    output logic       overflow,
    output ps2_state_t dbg_state
);

    ps2_state_t state;
    logic       lshift;
    logic       rshift;
    logic       evt_push;
    ps2_evt_t   evt_data;
    ps2_evt_t   head;
    logic       fifo_full;
    logic       fifo_empty;

`ifdef PS2_CAPS_LOCK_EN
    logic caps_q;
    logic caps_held;
    assign caps = caps_q;
`else
    assign caps = 1'b0;
`endif

    // Event record is registered, so it reaches the FIFO one edge after the byte.
    // shift snapshot uses lshift/rshift as they were before this byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            evt_push <= 1'b0;
            evt_data <= '0;
`ifdef PS2_CAPS_LOCK_EN
            caps_q    <= 1'b0;
            caps_held <= 1'b0;
`endif
        end else begin
            evt_push <= 1'b0;
            if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (byte_in == PS2_EXT) begin
                            state <= ST_EXT;
                        end else if (byte_in == PS2_BRK) begin
                            state <= ST_BRK;
                        end else if (byte_in == PS2_LSHIFT) begin
                            lshift <= 1'b1;
                        end else if (byte_in == PS2_RSHIFT) begin
                            rshift <= 1'b1;
                        end else if (is_status(byte_in)) begin
                            state <= ST_IDLE;
`ifdef PS2_CAPS_LOCK_EN
                        end else if (byte_in == PS2_CAPS) begin
                            // Typematic repeats of 58 must not re-toggle.
                            if (!caps_held) caps_q <= ~caps_q;
                            caps_held <= 1'b1;
`endif
                        end else begin
                            evt_push <= 1'b1;
                            evt_data <= '{code: byte_in, shift: lshift | rshift, ext: 1'b0};
                        end
                    end
                    ST_EXT: begin
                        if (byte_in == PS2_BRK) begin
                            state <= ST_EXT_BRK;
                        end else if (byte_in == PS2_EXT) begin
                            state <= ST_EXT;
                        end else if (byte_in == PS2_LSHIFT || byte_in == PS2_RSHIFT) begin
                            // E0 12 / E0 59 are fake shifts around Print Screen.
                            state <= ST_IDLE;
                        end else begin
                            evt_push <= 1'b1;
                            evt_data <= '{code: byte_in, shift: lshift | rshift, ext: 1'b1};
                            state    <= ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (byte_in != PS2_BRK) begin
                            state <= ST_IDLE;
                            if (byte_in == PS2_LSHIFT) lshift <= 1'b0;
                            if (byte_in == PS2_RSHIFT) rshift <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
                            if (byte_in == PS2_CAPS) caps_held <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    ps2_evt_fifo #(
        .WIDTH (PS2_EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_data (evt_data),
        .pop       (out_valid & out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign out_valid = !fifo_empty;
    assign char_out  = head.code;
    assign shift     = head.shift;
    assign ext       = head.ext;
    assign dbg_state = state;

endmodule

// File: tb/tb_ps2_key_events.sv
// tb_ps2_key_events: self-checking bench for ps2_key_events (DEPTH=4).
// A byte-level reference model turns each driven byte into expected events
// in exp_q; a negedge monitor checks every popped event against it and
// checks head stability while stalled.
module tb_ps2_key_events;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] char_out;
    logic       shift;
    logic       ext;
    logic       caps;
    logic       overflow;
    ps2_state_t dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int pop_cnt = 0;
    int ovf_cnt = 0;

    logic [9:0] exp_q[$];

    // reference model state
    bit m_ext, m_brk, m_ls, m_rs, m_caps, m_held;

    ps2_key_events #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .char_out   (char_out),
        .shift      (shift),
        .ext        (ext),
        .caps       (caps),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic bit m_is_status(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_brk) begin
            if (b != 8'hF0) begin
                m_brk = 0;
                if (b == 8'h12) m_ls = 0;
                if (b == 8'h59) m_rs = 0;
                if (b == 8'h58) m_held = 0;
            end
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'h12 || b == 8'h59) m_ext = 0;
            else begin
                exp_q.push_back({b, m_ls | m_rs, 1'b1});
                m_ext = 0;
            end
        end else begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'h12) m_ls = 1;
            else if (b == 8'h59) m_rs = 1;
            else if (m_is_status(b)) m_ext = 0;
`ifdef PS2_CAPS_LOCK_EN
            else if (b == 8'h58) begin
                if (!m_held) m_caps = ~m_caps;
                m_held = 1;
            end
`endif
            else exp_q.push_back({b, m_ls | m_rs, 1'b0});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk); #1;
        byte_in = b; byte_valid = 1'b1;
        model_byte(b);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    bit         hold = 0;
    logic [9:0] held_evt;
    logic [9:0] exp_evt;

    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (hold && out_valid) begin
                n_vec++;
                if ({char_out, shift, ext} !== held_evt) begin
                    n_err++;
                    $display("FAIL stall_stable: got %h expected %h", {char_out, shift, ext}, held_evt);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got code=%h shift=%b ext=%b, none expected",
                             char_out, shift, ext);
                end else begin
                    exp_evt = exp_q.pop_front();
                    if ({char_out, shift, ext} !== exp_evt) begin
                        n_err++;
                        $display("FAIL event: got code=%h shift=%b ext=%b expected code=%h shift=%b ext=%b",
                                 char_out, shift, ext, exp_evt[9:2], exp_evt[1], exp_evt[0]);
                    end
                end
            end
            if (overflow) ovf_cnt++;
            hold     = out_valid && !out_ready;
            held_evt = {char_out, shift, ext};
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        idle(3);
        n_vec++;
        if ({out_valid, char_out, shift, ext, overflow, caps} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0", {out_valid, char_out, shift, ext, overflow, caps});
        end
        n_vec++;
        if (dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        int p0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        byte_in = 8'h1C; byte_valid = 1'b1;
        model_byte(8'h1C);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: out_valid got %b expected 0", out_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({out_valid, char_out, shift, ext} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL latency_event: got v=%b code=%h s=%b e=%b expected v=1 code=1c s=0 e=0",
                     out_valid, char_out, shift, ext);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL one_cycle_valid: out_valid got %b expected 0", out_valid);
        end
        p0 = pop_cnt;
        drive_byte(8'hF0);
        drive_byte(8'h1C);
        idle(4);
        n_vec++;
        if (pop_cnt - p0 != 0) begin
            n_err++;
            $display("FAIL break_no_event: events got %0d expected 0", pop_cnt - p0);
        end
    endtask

    task automatic test_shift(input logic [7:0] sc);
        int p0;
        out_ready = 1'b1;
        p0 = pop_cnt;
        drive_byte(sc);
        drive_byte(8'h1C);
        drive_byte(8'hF0);
        drive_byte(sc);
        drive_byte(8'h1C);
        idle(4);
        n_vec++;
        if (pop_cnt - p0 != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL shift_events_%h: events got %0d expected 2", sc, pop_cnt - p0);
        end
    endtask

    task automatic test_ext();
        int p0;
        out_ready = 1'b1;
        p0 = pop_cnt;
        drive_byte(8'hE0); drive_byte(8'h75);
        drive_byte(8'hE0); drive_byte(8'hF0); drive_byte(8'h75);
        drive_byte(8'hE0); drive_byte(8'h12);
        idle(4);
        n_vec++;
        if (pop_cnt - p0 != 1) begin
            n_err++;
            $display("FAIL ext_events: events got %0d expected 1", pop_cnt - p0);
        end
        n_vec++;
        if (dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL ext_idle: state got %0d expected %0d", dbg_state, ST_IDLE);
        end
        // fake shift must not latch: next make reports shift=0 (checked by monitor)
        drive_byte(8'h1C);
        idle(4);
        n_vec++;
        if (pop_cnt - p0 != 2) begin
            n_err++;
            $display("FAIL fake_shift_follow: events got %0d expected 2", pop_cnt - p0);
        end
    endtask

    task automatic fill4();
        drive_byte(8'h16); drive_byte(8'h1E); drive_byte(8'h26); drive_byte(8'h25);
    endtask

    task automatic test_overflow();
        int p0, o0;
        out_ready = 1'b0;
        p0 = pop_cnt; o0 = ovf_cnt;
        fill4();
        drive_byte(8'h2E);
        void'(exp_q.pop_back());  // fifth make is dropped
        idle(3);
        n_vec++;
        if (ovf_cnt - o0 != 1) begin
            n_err++;
            $display("FAIL overflow_pulse: pulses got %0d expected 1", ovf_cnt - o0);
        end
        out_ready = 1'b1;
        idle(8);
        out_ready = 1'b0;
        n_vec++;
        if (pop_cnt - p0 != 4 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_drain: events got %0d valid=%b expected 4 valid=0",
                     pop_cnt - p0, out_valid);
        end
    endtask

    task automatic test_full_pop_push();
        int p0, o0;
        out_ready = 1'b0;
        fill4();
        idle(2);
        p0 = pop_cnt; o0 = ovf_cnt;
        @(posedge clk); #1;
        byte_in = 8'h2E; byte_valid = 1'b1;
        model_byte(8'h2E);
        @(posedge clk); #1;           // event registered; lands at next edge
        byte_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;           // pop and push on the same edge
        out_ready = 1'b0;
        idle(3);
        n_vec++;
        if (ovf_cnt - o0 != 0 || pop_cnt - p0 != 1) begin
            n_err++;
            $display("FAIL full_pop_push: ovf got %0d pops %0d expected 0 and 1",
                     ovf_cnt - o0, pop_cnt - p0);
        end
        out_ready = 1'b1;
        idle(8);
        out_ready = 1'b0;
        n_vec++;
        if (pop_cnt - p0 != 5 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL full_pop_count: events got %0d expected 5", pop_cnt - p0);
        end
    endtask

    task automatic test_reset_mid_prefix();
        int p0;
        out_ready = 1'b1;
        drive_byte(8'hF0);
        apply_reset();
        p0 = pop_cnt;
        drive_byte(8'h1C);
        idle(4);
        n_vec++;
        if (pop_cnt - p0 != 1) begin
            n_err++;
            $display("FAIL reset_mid_prefix: events got %0d expected 1", pop_cnt - p0);
        end
    endtask

    task automatic test_caps();
        int p0;
        out_ready = 1'b1;
        p0 = pop_cnt;
        drive_byte(8'h58);
`ifdef PS2_CAPS_LOCK_EN
        n_vec++;
        if (caps !== 1'b1) begin n_err++; $display("FAIL caps_on: got %b expected 1", caps); end
        drive_byte(8'h58);
        n_vec++;
        if (caps !== 1'b1) begin n_err++; $display("FAIL caps_repeat: got %b expected 1", caps); end
        drive_byte(8'hF0); drive_byte(8'h58);
        drive_byte(8'h58);
        idle(3);
        n_vec++;
        if (caps !== 1'b0 || pop_cnt - p0 != 0) begin
            n_err++;
            $display("FAIL caps_off: caps=%b events=%0d expected 0 and 0", caps, pop_cnt - p0);
        end
`else
        idle(3);
        n_vec++;
        if (caps !== 1'b0 || pop_cnt - p0 != 1) begin
            n_err++;
            $display("FAIL caps_plain_key: caps=%b events=%0d expected 0 and 1", caps, pop_cnt - p0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [11];
        int p0;
        seq = '{8'h1C, 8'h12, 8'h32, 8'hF0, 8'h12, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74, 8'h21};
        out_ready = 1'b1;
        p0 = pop_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            byte_in = seq[i]; byte_valid = 1'b1;
            model_byte(seq[i]);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        idle(6);
        n_vec++;
        if (pop_cnt - p0 != 4 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL back_to_back: events got %0d expected 4", pop_cnt - p0);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [10];
        logic [7:0] b;
        int o0;
        pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h58, 8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
        o0 = ovf_cnt;
        for (int r = 0; r < 30; r++) begin
            // at most 4 bytes per round, so at most 4 events: the FIFO cannot overflow
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 0) b = pool[$urandom_range(0, 9)];
                else b = 8'($urandom_range(0, 255));
                out_ready = 1'($urandom_range(0, 1));
                drive_byte(b);
            end
            out_ready = 1'b1;
            idle(7);
            n_vec++;
            if (exp_q.size() != 0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL random_round%0d: pending=%0d valid=%b expected 0 and 0",
                         r, exp_q.size(), out_valid);
                exp_q.delete();
            end
            n_vec++;
            if (caps !== 1'(m_caps)) begin
                n_err++;
                $display("FAIL random_caps%0d: got %b expected %b", r, caps, m_caps);
            end
        end
        n_vec++;
        if (ovf_cnt != o0) begin
            n_err++;
            $display("FAIL random_overflow: pulses got %0d expected 0", ovf_cnt - o0);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_shift(8'h12);
        test_shift(8'h59);
        test_ext();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_prefix();
        test_caps();
        test_back_to_back();
        apply_reset();
        test_random();
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
